// File: rtl/ifu_fetch_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
//
// Handshake: the master holds imem_req high with imem_addr stable until the
// slave returns imem_ack; imem_ack with imem_rdata valid completes the
// transfer in that same cycle. imem_ack is ignored while imem_req is low.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: SCCPU instruction fetch unit. Owns the PC, fetches one word per
// instruction over the imem bus, holds it for the EXEC cycle(s) and commits
// the next PC chosen by npc_op.
// Optional feature macro: IFU_ALIGN_CHECK_EN (misaligned jump-register halts
// the core and sets the sticky misalign flag; otherwise the target is
// silently word-aligned).
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifu_fetch_if.master   imem,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  input  logic [1:0]    npc_op,
  input  logic [31:0]   rs_data,
  input  logic          stall,
  output logic          commit,
  output logic          misalign,
  output logic [1:0]    fsm_state
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JREG   = 2'b11;

  logic [1:0]  state;
  logic [31:0] npc;
  logic        jr_bad;

  assign fsm_state = state;
  assign pc_plus4  = pc + 32'd4;

`ifdef IFU_ALIGN_CHECK_EN
  // A jump-register to a non-word address faults instead of committing.
  assign jr_bad = (state == S_EXEC) && (npc_op == NPC_JREG) && (rs_data[1:0] != 2'b00);
`else
  assign jr_bad = 1'b0;
`endif

  // Reset overrides the request and the commit pulse in the same cycle.
  assign imem.imem_req  = (state == S_FETCH) && !rst;
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == S_EXEC) && !rst;
  assign commit         = (state == S_EXEC) && !stall && !rst && !jr_bad;

  // Next-PC selection from the decoder's op code, modulo 2^32.
  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      NPC_PLUS4:  npc = pc_plus4;
      NPC_BRANCH: npc = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      NPC_JREG:   npc = {rs_data[31:2], 2'b00};
      default:    npc = pc_plus4;
    endcase
  end

  // FSM, PC and instruction register; PC moves only on a commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      instr <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem.imem_ack) begin
            instr <= imem.imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (jr_bad) begin
            state <= S_HALT;
          end else if (!stall) begin
            pc    <= npc;
            state <= S_FETCH;
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        S_HALT: state <= S_HALT;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else if (jr_bad) misalign <= 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: table of single-instruction vectors
// followed by hand-written reset and jump-register corner sequences.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  npc_op;
  logic [31:0] rs_data;
  logic        stall;
  logic        commit;
  logic        misalign;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  ifu_fetch_if imem_bus ();

  ifu_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .npc_op      (npc_op),
    .rs_data     (rs_data),
    .stall       (stall),
    .commit      (commit),
    .misalign    (misalign),
    .fsm_state   (fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  op;
    logic [31:0] rs;
    int          ack_dly;
    int          stall_n;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full instruction: FETCH (with ack latency), EXEC (with stalls), commit.
  task automatic run_instr(input logic [31:0] rdata, input logic [1:0] op, input logic [31:0] rs,
                           input int ack_dly, input int stall_n,
                           input logic [31:0] exp_pc, input logic [31:0] exp_npc);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'hDEAD_BEEF;
      npc_op = ~op; rs_data = ~rs; stall = 1'b1;
      #1;
      check("wait_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check("wait_addr", imem_bus.imem_addr, exp_pc);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    @(negedge clk);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = rdata;
    npc_op = ~op; rs_data = ~rs; stall = 1'b0;
    #1;
    check("fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
    check("fetch_addr", imem_bus.imem_addr, exp_pc);
    check("fetch_commit", {31'd0, commit}, 32'd0);
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = ~rdata;  // spurious ack
      npc_op = op; rs_data = rs; stall = 1'b1;
      #1;
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr, rdata);
      check("stall_commit", {31'd0, commit}, 32'd0);
      check("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("stall_pc", pc, exp_pc);
    end
    @(negedge clk);
    imem_bus.imem_ack = 1'b0; npc_op = op; rs_data = rs; stall = 1'b0;
    #1;
    check("exec_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_instr", instr, rdata);
    check("exec_commit", {31'd0, commit}, 32'd1);
    check("exec_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
    @(posedge clk);
    #1;
    check("next_pc", pc, exp_npc);
    check("post_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 2'b00, 32'h0,         0, 0, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'hA5A5_0001, 2'b00, 32'h0,         3, 2, 32'h0000_0004, 32'h0000_0008};
    vecs[2] = '{32'h0000_0000, 2'b11, 32'h0000_0100, 0, 0, 32'h0000_0008, 32'h0000_0100};
    vecs[3] = '{32'h1000_FFFF, 2'b01, 32'h0,         0, 0, 32'h0000_0100, 32'h0000_0100};
    vecs[4] = '{32'h1000_0003, 2'b01, 32'h0,         0, 1, 32'h0000_0100, 32'h0000_0110};
    vecs[5] = '{32'h0000_0000, 2'b11, 32'h3000_0010, 1, 0, 32'h0000_0110, 32'h3000_0010};
    vecs[6] = '{32'h0800_0040, 2'b10, 32'h0,         0, 0, 32'h3000_0010, 32'h3000_0100};
    vecs[7] = '{32'h0000_0000, 2'b11, 32'hFFFF_FFFC, 0, 0, 32'h3000_0100, 32'hFFFF_FFFC};
    vecs[8] = '{32'h0000_0000, 2'b00, 32'h0,         0, 0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[9] = '{32'h0000_0000, 2'b11, 32'h0000_2000, 0, 0, 32'h0000_0000, 32'h0000_2000};

    rst = 1'b1; stall = 1'b0; npc_op = 2'b00; rs_data = 32'h0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;

    // Reset held two cycles; request must stay low throughout.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("rst_commit", {31'd0, commit}, 32'd0);
      if (i == 1) begin
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
      end
    end
    rst = 1'b0;

    for (int v = 0; v < 10; v++)
      run_instr(vecs[v].rdata, vecs[v].op, vecs[v].rs, vecs[v].ack_dly, vecs[v].stall_n,
                vecs[v].exp_pc, vecs[v].exp_npc);

    // Reset during EXEC with a jump pending: no commit, PC back to reset value.
    @(negedge clk);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0800_0040; npc_op = 2'b10;
    #1;
    check("rx_fetch_req", {31'd0, imem_bus.imem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1; imem_bus.imem_ack = 1'b0; stall = 1'b0;
    #1;
    check("rx_commit", {31'd0, commit}, 32'd0);
    check("rx_req", {31'd0, imem_bus.imem_req}, 32'd0);
    @(posedge clk);
    #1;
    check("rx_pc", pc, 32'h0);
    check("rx_instr", instr, 32'h0);
    check("rx_valid", {31'd0, instr_valid}, 32'd0);

    // Reset coinciding with an ack: the fetched word is dropped.
    @(negedge clk);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1234_5678;
    #1;
    check("ra_req", {31'd0, imem_bus.imem_req}, 32'd0);
    @(posedge clk);
    #1;
    check("ra_instr", instr, 32'h0);
    check("ra_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0; imem_bus.imem_ack = 1'b0;
    #1;
    check("ra_req_after", {31'd0, imem_bus.imem_req}, 32'd1);
    check("ra_addr_after", imem_bus.imem_addr, 32'h0);

    // Jump register: aligned, then misaligned.
    run_instr(32'h0, 2'b11, 32'h0000_2000, 0, 0, 32'h0, 32'h0000_2000);
`ifdef IFU_ALIGN_CHECK_EN
    @(negedge clk);
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h0;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0; npc_op = 2'b11; rs_data = 32'h0000_2002; stall = 1'b0;
    #1;
    check("mis_commit", {31'd0, commit}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      imem_bus.imem_ack = 1'b1;
      #1;
      check("mis_flag", {31'd0, misalign}, 32'd1);
      check("mis_req", {31'd0, imem_bus.imem_req}, 32'd0);
      check("mis_pc", pc, 32'h0000_2000);
      check("mis_valid", {31'd0, instr_valid}, 32'd0);
    end
`else
    run_instr(32'h0, 2'b11, 32'h0000_2002, 0, 0, 32'h0000_2000, 32'h0000_2000);
    check("mis_flag", {31'd0, misalign}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
